// File: rtl/sd_dma_wb_sink.sv
// rtl/sd_dma_wb_sink.sv - Wishbone DMA write sink buffering words into a FWFT stream FIFO
// Optional byte reversal of stored words: define SD_DMA_BYTE_SWAP_EN.
module sd_dma_wb_sink #(
    parameter int          FIFO_DEPTH      = 16,
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter int          ADDR_SPAN_LOG2  = 20,
    parameter int          WORDS_PER_BLOCK = 128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   wb_adr_i,
    input  logic [31:0]                   wb_dat_i,
    output logic [31:0]                   wb_dat_o,
    input  logic [3:0]                    wb_sel_i,
    input  logic                          wb_we_i,
    input  logic                          wb_cyc_i,
    input  logic                          wb_stb_i,
    output logic                          wb_ack_o,
    input  logic [2:0]                    wb_cti_i,
    input  logic [1:0]                    wb_bte_i,
    output logic [31:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   word_count,
    output logic                          block_done,
    output logic                          rd_seen,
    output logic                          addr_err,
    input  logic                          clr_stats
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(WORDS_PER_BLOCK);
    localparam logic [BW-1:0] BLK_LAST = BW'(WORDS_PER_BLOCK - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [BW-1:0] blk_cnt;
    logic          req;
    logic          in_win;
    logic          full;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   masked;
    logic [31:0]   stored;
    logic          unused;

    assign unused = &{1'b0, wb_bte_i, wb_adr_i[ADDR_SPAN_LOG2-1:0]};

    assign req    = wb_cyc_i & wb_stb_i;
    assign in_win = (wb_adr_i[31:ADDR_SPAN_LOG2] == ADDR_BASE[31:ADDR_SPAN_LOG2]);
    assign full   = (level == FULL_LVL);
    // Only in-window writes need room; reads and stray writes are always acked.
    assign accept = req & (~wb_ack_o | (wb_cti_i == 3'b010)) & ~(wb_we_i & in_win & full);
    assign push   = accept & wb_we_i & in_win;
    assign pop    = (level != '0) & out_ready;

    always_comb begin
        masked = '0;
        for (int i = 0; i < 4; i++) begin
            masked[8*i +: 8] = wb_sel_i[i] ? wb_dat_i[8*i +: 8] : 8'h00;
        end
    end

`ifdef SD_DMA_BYTE_SWAP_EN
    assign stored = {masked[7:0], masked[15:8], masked[23:16], masked[31:24]};
`else
    assign stored = masked;
`endif

    assign out_data   = mem[rd_ptr];
    assign out_valid  = (level != '0);
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= stored;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            word_count <= '0;
            blk_cnt    <= '0;
            block_done <= 1'b0;
            rd_seen    <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            wb_ack_o   <= accept;
            block_done <= 1'b0;
            if (accept & ~wb_we_i) begin
                wb_dat_o <= '0;
                rd_seen  <= 1'b1;
            end
            if (accept & wb_we_i & ~in_win) begin
                addr_err <= 1'b1;
            end
            if (push) begin
                wr_ptr     <= wr_ptr + AW'(1);
                word_count <= word_count + 32'd1;
                if (blk_cnt == BLK_LAST) begin
                    blk_cnt    <= '0;
                    block_done <= 1'b1;
                end else begin
                    blk_cnt <= blk_cnt + BW'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
            // A clear on the same edge as a push drops that word from the statistics.
            if (clr_stats) begin
                word_count <= '0;
                blk_cnt    <= '0;
                block_done <= 1'b0;
                rd_seen    <= 1'b0;
                addr_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sd_dma_wb_sink.sv
// tb/tb_sd_dma_wb_sink.sv - self-checking bench for sd_dma_wb_sink (SD_DMA_BYTE_SWAP_EN aware)
module tb_sd_dma_wb_sink;

    localparam int WPB   = 128;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, clr = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        man_ready = 1'b0, rr = 1'b0, rand_mode = 1'b0;
    logic        out_ready;
    logic [31:0] wb_dat_o, out_data, word_count;
    logic        wb_ack_o, out_valid, block_done, rd_seen, addr_err;
    logic [4:0]  fifo_level;

    assign out_ready = rand_mode ? rr : man_ready;

    sd_dma_wb_sink dut (
        .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(wb_dat_o),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(wb_ack_o),
        .wb_cti_i(cti), .wb_bte_i(bte), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level), .word_count(word_count),
        .block_done(block_done), .rd_seen(rd_seen), .addr_err(addr_err), .clr_stats(clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] stored_word(input logic [31:0] d, input logic [3:0] s);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = s[i] ? d[8*i +: 8] : 8'h00;
`ifdef SD_DMA_BYTE_SWAP_EN
        return {b[0], b[1], b[2], b[3]};
`else
        return {b[3], b[2], b[1], b[0]};
`endif
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return (a >> 20) == 0;
    endfunction

    // Reference model: expected stream contents plus statistics since the last clear.
    logic [31:0] mq[$];
    bit          pend_push = 0, pend_rd = 0, pend_aerr = 0;
    logic [31:0] pend_word = '0;
    logic [31:0] m_cnt = '0;
    int          m_blk = 0;
    bit          m_rd = 0, m_aerr = 0, exp_bd = 0;
    bit          p_reset = 1, p_ready = 0, p_clr = 0;
    bit          mon_en = 1;
    int          peak = 0, bd_count = 0, acks = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (p_reset) begin
                mq.delete();
                m_cnt = '0; m_blk = 0; m_rd = 0; m_aerr = 0; exp_bd = 0;
            end else begin
                if (p_ready && mq.size() > 0) void'(mq.pop_front());
                exp_bd = 0;
                if (pend_push) begin
                    mq.push_back(pend_word);
                    if (!p_clr) begin
                        m_cnt++;
                        m_blk++;
                        if (m_blk == WPB) begin m_blk = 0; exp_bd = 1; end
                    end
                end
                if (pend_rd)   m_rd = 1;
                if (pend_aerr) m_aerr = 1;
                if (p_clr) begin m_cnt = '0; m_blk = 0; m_rd = 0; m_aerr = 0; end
            end
            pend_push = 0; pend_rd = 0; pend_aerr = 0;
            check("mon_level", 32'(fifo_level), 32'(mq.size()));
            check("mon_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) check("mon_data", out_data, mq[0]);
            check("mon_word_count", word_count, m_cnt);
            check("mon_block_done", 32'(block_done), 32'(exp_bd));
            check("mon_rd_seen", 32'(rd_seen), 32'(m_rd));
            check("mon_addr_err", 32'(addr_err), 32'(m_aerr));
            check("mon_dat_o", wb_dat_o, 32'h0);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (block_done) bd_count++;
            p_reset = reset; p_ready = out_ready; p_clr = clr;
        end
    end

    always @(posedge clk) begin
        #1 rr = 1'($urandom % 2);
    end

    task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input logic [2:0] c, input int budget, output bit ok);
        adr = a; dat = d; sel = s; we = w; cti = c; cyc = 1'b1; stb = 1'b1; ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge clk); #1;
            if (wb_ack_o) ok = 1;
        end
        if (ok) begin
            acks++;
            if (w && in_window(a)) begin pend_push = 1; pend_word = stored_word(d, s); end
            else if (w) pend_aerr = 1;
            else pend_rd = 1;
        end
    endtask

    task automatic idle();
        cyc = 1'b0; stb = 1'b0; cti = 3'b000; we = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        man_ready = 1'b1;
        for (int i = 0; i < 40 && out_valid; i++) begin @(posedge clk); #1; end
        check("drain_empty", 32'(out_valid), 32'h0);
        man_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        w;
        logic        exp_push;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl [6];
    bit   ok;
    int   stall_idx, stall_cnt;

    initial begin
`ifdef SD_DMA_BYTE_SWAP_EN
        tbl[0] = '{32'h0000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b1, 32'hEFBE_ADDE};
        tbl[1] = '{32'h0000_0008, 32'h1122_3344, 4'b0101, 1'b1, 1'b1, 32'h4400_2200};
        tbl[2] = '{32'h000F_FFFC, 32'hA5A5_0F0F, 4'b1010, 1'b1, 1'b1, 32'h000F_00A5};
`else
        tbl[0] = '{32'h0000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[1] = '{32'h0000_0008, 32'h1122_3344, 4'b0101, 1'b1, 1'b1, 32'h0022_0044};
        tbl[2] = '{32'h000F_FFFC, 32'hA5A5_0F0F, 4'b1010, 1'b1, 1'b1, 32'hA500_0F00};
`endif
        tbl[3] = '{32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{32'h0010_0000, 32'h5555_AAAA, 4'b1111, 1'b1, 1'b0, 32'h0};
        tbl[5] = '{32'hFFF0_0000, 32'h1234_5678, 4'b1111, 1'b1, 1'b0, 32'h0};

        cycles(3);
        check("reset_ack", 32'(wb_ack_o), 32'h0);
        check("reset_level", 32'(fifo_level), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_word_count", word_count, 32'h0);
        reset = 1'b0;
        cycles(1);

        // Classic single transfers from the vector table.
        for (int i = 0; i < 6; i++) begin
            beat(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].w, 3'b000, 10, ok);
            check("classic_acked", 32'(ok), 32'h1);
            idle();
            cycles(1);
            check("classic_ack_one_cycle", 32'(wb_ack_o), 32'h0);
            check("classic_valid", 32'(out_valid), 32'(tbl[i].exp_push));
            if (tbl[i].exp_push) check("classic_data", out_data, tbl[i].exp_word);
            if (i == 0) check("first_word_count", word_count, 32'h1);
            man_ready = 1'b1; cycles(1); man_ready = 1'b0;
        end
        check("flag_rd_seen", 32'(rd_seen), 32'h1);
        check("flag_addr_err", 32'(addr_err), 32'h1);
        check("table_word_count", word_count, 32'h3);
        clr = 1'b1; cycles(1); clr = 1'b0;
        check("clr_rd_seen", 32'(rd_seen), 32'h0);
        check("clr_addr_err", 32'(addr_err), 32'h0);
        check("clr_word_count", word_count, 32'h0);

        // 20-beat burst into a stalled consumer.
        peak = 0; stall_cnt = 0; stall_idx = -1;
        for (int i = 0; i < 20; i++) begin
            beat(32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b1,
                 (i == 19) ? 3'b111 : 3'b010, 30, ok);
            if (!ok) begin
                stall_cnt++; stall_idx = i;
                check("stall_level", 32'(fifo_level), 32'(DEPTH));
                check("stall_ack_low", 32'(wb_ack_o), 32'h0);
                man_ready = 1'b1;
                beat(32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b1, 3'b010, 30, ok);
                check("stall_resume", 32'(ok), 32'h1);
            end
        end
        idle();
        check("stall_count", 32'(stall_cnt), 32'h1);
        check("stall_index", 32'(stall_idx), 32'd16);
        check("burst_peak", 32'(peak), 32'(DEPTH));
        drain();

        // One full block with a free-running consumer.
        clr = 1'b1; cycles(1); clr = 1'b0;
        cycles(1);
        peak = 0; bd_count = 0; man_ready = 1'b1;
        for (int i = 0; i < WPB; i++) begin
            beat(32'h200, $urandom, 4'hF, 1'b1, (i == WPB-1) ? 3'b111 : 3'b010, 10, ok);
            if (!ok) check("block_beat_acked", 32'(ok), 32'h1);
        end
        idle();
        cycles(3);
        check("block_done_pulses", 32'(bd_count), 32'h1);
        check("block_word_count", word_count, 32'd128);
        check("block_peak_level", 32'(peak), 32'h1);

        // Clear on the same edge as a push: the word is buffered but not counted.
        clr = 1'b1;
        beat(32'h300, 32'h0BAD_F00D, 4'hF, 1'b1, 3'b000, 10, ok);
        clr = 1'b0;
        idle();
        check("clr_push_word_count", word_count, 32'h0);
        cycles(2);
        drain();

        // Reset in the middle of a burst with five words buffered.
        for (int i = 0; i < 5; i++) begin
            beat(32'h400 + 32'(4*i), 32'h5000 + 32'(i), 4'hF, 1'b1, 3'b010, 10, ok);
            if (!ok) check("pre_reset_beat", 32'(ok), 32'h1);
        end
        adr = 32'h414; dat = 32'h5005; cti = 3'b010;
        reset = 1'b1;
        cycles(1);
        check("midrst_ack", 32'(wb_ack_o), 32'h0);
        check("midrst_level", 32'(fifo_level), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_word_count", word_count, 32'h0);
        reset = 1'b0;
        idle();
        cycles(1);
        man_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(32'h500 + 32'(4*i), 32'h6000 + 32'(i), 4'hF, 1'b1, (i == 3) ? 3'b111 : 3'b010, 10, ok);
            check("fresh_beat", 32'(ok), 32'h1);
        end
        idle();
        cycles(2);
        check("fresh_word_count", word_count, 32'h4);

        // Randomised traffic against the model with a random consumer.
        rand_mode = 1'b1;
        for (int b = 0; b < 60; b++) begin
            int len;
            bit classic;
            len = $urandom_range(1, 8);
            classic = (len == 1) && ($urandom % 2 == 1);
            for (int i = 0; i < len; i++) begin
                logic [31:0] a;
                logic [2:0]  c;
                a = ($urandom % 10 == 0) ? (32'h0040_0000 | ($urandom & 32'hFFFC))
                                         : ($urandom & 32'h000F_FFFC);
                c = classic ? 3'b000 : ((i == len-1) ? 3'b111 : 3'b010);
                beat(a, $urandom, 4'($urandom), ($urandom % 8 != 0), c, 200, ok);
                check("rand_beat_acked", 32'(ok), 32'h1);
            end
            idle();
            cycles($urandom_range(0, 2));
            if ($urandom % 8 == 0) begin clr = 1'b1; cycles(1); clr = 1'b0; end
        end
        rand_mode = 1'b0;
        cycles(1);
        drain();
        cycles(2);
        check("final_level", 32'(fifo_level), 32'h0);
        mon_en = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
